// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - digit-serial adder/subtractor with start/busy/done handshake
// Optional macro ADDSUB_SAT_EN: signed saturation of res on overflow.
module addsub_seq #(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cy;
  logic               sub_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic [DIGIT_W-1:0] a_d;
  logic [DIGIT_W-1:0] b_d;
  logic [DIGIT_W-1:0] sum_d;
  logic [DIGIT_W:0]   c;
  logic               last;
  logic               ov_d;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   res_fin;

  // Operands shift right each RUN cycle, so the current digit is always at the bottom.
  assign a_d  = a_q[DIGIT_W-1:0];
  assign b_d  = b_q[DIGIT_W-1:0] ^ {DIGIT_W{sub_q}};
  assign last = (cnt == CNT_W'(N - 1));
  assign ov_d = c[DIGIT_W] ^ c[DIGIT_W-1];

  // Bit-level ripple inside the digit exposes the carry into the MSB for overflow.
  always_comb begin
    c     = '0;
    sum_d = '0;
    c[0]  = cy;
    for (int j = 0; j < DIGIT_W; j++) begin
      sum_d[j] = a_d[j] ^ b_d[j] ^ c[j];
      c[j+1]   = (a_d[j] & b_d[j]) | (c[j] & (a_d[j] ^ b_d[j]));
    end
  end

  always_comb begin
    res_next = res;
    res_next[int'(cnt)*DIGIT_W +: DIGIT_W] = sum_d;
`ifdef ADDSUB_SAT_EN
    // On the last digit a_d holds A's sign bit in its top position.
    if (ov_d)
      res_fin = a_d[DIGIT_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      res_fin = res_next;
`else
    res_fin = res_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cy       <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      res      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            state    <= S_RUN;
            a_q      <= a;
            b_q      <= b;
            sub_q    <= sub_mode;
            cy       <= sub_mode;
            cnt      <= '0;
            res      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q <= a_q >> DIGIT_W;
          b_q <= b_q >> DIGIT_W;
          cy  <= c[DIGIT_W];
          cnt <= cnt + 1'b1;
          res <= res_next;
          if (last) begin
            state    <= S_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            res      <= res_fin;
            carry    <= c[DIGIT_W];
            overflow <= ov_d;
            zero     <= (res_fin == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// tb/tb_addsub_seq.sv - directed self-checking bench for addsub_seq (WIDTH=8, DIGIT_W=2)
module tb_addsub_seq;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub_mode;
  logic       busy;
  logic       done;
  logic [7:0] res;
  logic       carry;
  logic       overflow;
  logic       zero;

  int n_assert = 0;
  int n_fail   = 0;

  addsub_seq #(.WIDTH(8), .DIGIT_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sub_mode(sub_mode),
    .busy(busy), .done(done), .res(res), .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

`ifdef ADDSUB_SAT_EN
  localparam logic [7:0] OV_POS_RES = 8'h7F;
  localparam logic [7:0] OV_NEG_RES = 8'h80;
`else
  localparam logic [7:0] OV_POS_RES = 8'h80;
  localparam logic [7:0] OV_NEG_RES = 8'h7F;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge with the block idle; returns on a negedge with the block idle.
  task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic os,
                        input logic [7:0] er, input logic ec, input logic eo,
                        input logic ez, input string tag);
    a = oa; b = ob; sub_mode = os; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~oa; b = ~ob; sub_mode = ~os;
    for (int i = 0; i < N; i++) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " no_done"}, done, 0);
      @(negedge clk);
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy_low"}, busy, 0);
    check({tag, " res"}, res, er);
    check({tag, " carry"}, carry, ec);
    check({tag, " overflow"}, overflow, eo);
    check({tag, " zero"}, zero, ez);
    @(negedge clk);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " res_hold"}, res, er);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0; sub_mode = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst res", res, 8'h00);
    check("rst carry", carry, 0);
    check("rst overflow", overflow, 0);
    check("rst zero", zero, 1);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'h3C, 8'h15, 1'b0, 8'h51, 1'b0, 1'b0, 1'b0, "add");
    run_op(8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, "sub_eq");
    run_op(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "sub_borrow");
    run_op(8'h7F, 8'h01, 1'b0, OV_POS_RES, 1'b0, 1'b1, 1'b0, "ov_add");
    run_op(8'h80, 8'h01, 1'b1, OV_NEG_RES, 1'b1, 1'b1, 1'b0, "ov_sub");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "carry_out");

    // start re-pulsed mid-RUN with other operands must be ignored
    a = 8'h10; b = 8'h20; sub_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h01; b = 8'h01; sub_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("restart busy", busy, 1);
    @(negedge clk);
    check("restart done", done, 1);
    check("restart res", res, 8'h30);

    // start held in the DONE cycle: back-to-back 0x40-0x02
    a = 8'h40; b = 8'h02; sub_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("b2b busy", busy, 1);
      check("b2b no_done", done, 0);
      @(negedge clk);
    end
    check("b2b done", done, 1);
    check("b2b res", res, 8'h3E);
    check("b2b carry", carry, 1);
    @(negedge clk);

    // reset at the second RUN cycle discards the operation
    a = 8'h55; b = 8'h11; sub_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst res", res, 8'h00);
    check("midrst zero", zero, 1);
    check("midrst done", done, 0);
    for (int i = 0; i < N + 1; i++) begin
      @(negedge clk);
      check("midrst no_done", done, 0);
    end
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, "post_rst");

    // reset wins over start in the same cycle
    reset = 1'b1; start = 1'b1; a = 8'h01; b = 8'h02;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_vs_start busy", busy, 0);
    @(negedge clk);
    check("rst_vs_start idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
